// File: rtl/eight_to_one_mux_if.sv
// eight_to_one_mux_if: data, select and result signals of the 8:1 selector
interface eight_to_one_mux_if #(parameter int WIDTH = 1);
    logic [WIDTH-1:0] I0, I1, I2, I3, I4, I5, I6, I7;
    logic             S0, S1, S2, Enable;
    logic [WIDTH-1:0] Y, Y_r;
    logic [2:0]       Sel_r;
    modport master (output I0, I1, I2, I3, I4, I5, I6, I7, S0, S1, S2, Enable,
                    input Y, Y_r, Sel_r);
    modport slave  (input I0, I1, I2, I3, I4, I5, I6, I7, S0, S1, S2, Enable,
                    output Y, Y_r, Sel_r);
endinterface

// File: rtl/eight_to_one_mux.sv
// eight_to_one_mux: enabled 8:1 selector with combinational and registered results
module eight_to_one_mux #(parameter int WIDTH = 1) (
    input logic             clk,
    input logic             rst_n,
    eight_to_one_mux_if.slave bus
);
    logic [2:0]       sel;
    logic [WIDTH-1:0] d [8];
    // Indexing with an X/Z select yields X, so unknown selects stay visible in simulation
    always_comb begin
        sel  = {bus.S2, bus.S1, bus.S0};
        d[0] = bus.I0;
        d[1] = bus.I1;
        d[2] = bus.I2;
        d[3] = bus.I3;
        d[4] = bus.I4;
        d[5] = bus.I5;
        d[6] = bus.I6;
        d[7] = bus.I7;
        bus.Y = bus.Enable ? d[sel] : '0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.Y_r   <= '0;
            bus.Sel_r <= '0;
        end else begin
            bus.Y_r   <= bus.Y;
            bus.Sel_r <= sel;
        end
    end
endmodule

// File: tb/tb_eight_to_one_mux.sv
// tb_eight_to_one_mux: directed and random checks of 1-bit and 16-bit selector instances
module tb_eight_to_one_mux;
    logic clk = 0;
    logic rst_n = 0;
    int   checks = 0;
    int   failures = 0;
    eight_to_one_mux_if #(.WIDTH(1))  ifa ();
    eight_to_one_mux_if #(.WIDTH(16)) ifb ();
    eight_to_one_mux #(.WIDTH(1))  dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    eight_to_one_mux #(.WIDTH(16)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
    always #5 clk = ~clk;

    logic [7:0]  a_bits = 0;
    logic [2:0]  a_sel = 0, b_sel = 0;
    logic        a_en = 0, b_en = 0;
    logic [15:0] w [8];

    function automatic logic [15:0] mdl_a();
        return a_en ? 16'(a_bits[a_sel]) : 16'h0;
    endfunction
    function automatic logic [15:0] mdl_b();
        return b_en ? w[b_sel] : 16'h0;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_a(input logic [7:0] bits, input logic [2:0] sel, input logic en);
        a_bits = bits; a_sel = sel; a_en = en;
        {ifa.I7, ifa.I6, ifa.I5, ifa.I4, ifa.I3, ifa.I2, ifa.I1, ifa.I0} = bits;
        {ifa.S2, ifa.S1, ifa.S0} = sel;
        ifa.Enable = en;
        #1 chk("y_a", 16'(ifa.Y), mdl_a());
    endtask

    task automatic drive_b(input logic [2:0] sel, input logic en);
        b_sel = sel; b_en = en;
        {ifb.I7, ifb.I6, ifb.I5, ifb.I4, ifb.I3, ifb.I2, ifb.I1, ifb.I0} =
            {w[7], w[6], w[5], w[4], w[3], w[2], w[1], w[0]};
        {ifb.S2, ifb.S1, ifb.S0} = sel;
        ifb.Enable = en;
        #1 chk("y_b", ifb.Y, mdl_b());
    endtask

    task automatic tick();
        logic [15:0] ea, eb;
        ea = mdl_a();
        eb = mdl_b();
        @(posedge clk);
        #1;
        chk("y_r_a", 16'(ifa.Y_r), ea);
        chk("sel_r_a", 16'(ifa.Sel_r), 16'(a_sel));
        chk("y_r_b", ifb.Y_r, eb);
        chk("sel_r_b", 16'(ifb.Sel_r), 16'(b_sel));
    endtask

    initial begin
        for (int k = 0; k < 8; k++) w[k] = 16'h0;
        drive_b(3'd0, 1'b0);
        drive_a(8'b0000_1000, 3'd3, 1'b1);
        #3;
        chk("rst_y_r_a", 16'(ifa.Y_r), 16'h0);
        chk("rst_sel_r_a", 16'(ifa.Sel_r), 16'h0);
        chk("rst_y_r_b", ifb.Y_r, 16'h0);
        drive_a(8'b1111_0111, 3'd3, 1'b1);
        @(negedge clk) rst_n = 1;
        for (int i = 0; i < 8; i++) begin
            drive_a(8'b1 << i, 3'(i), 1'b1);
            #9 chk("walk1_hold", 16'(ifa.Y), 16'h1);
        end
        for (int i = 0; i < 8; i++) drive_a(8'b1111_1110, 3'(i), 1'b1);
        drive_a(8'hFF, 3'd0, 1'b0);
        tick();
        for (int i = 0; i < 8; i++) drive_a(8'hFF, 3'(i), 1'b0);
        drive_a(8'b0010_0000, 3'b101, 1'b1);
        tick();
        #2 rst_n = 0;
        #1;
        chk("async_y_r", 16'(ifa.Y_r), 16'h0);
        chk("async_sel_r", 16'(ifa.Sel_r), 16'h0);
        drive_a(8'b0100_0000, 3'd6, 1'b1);
        drive_a(8'b1011_1111, 3'd6, 1'b1);
        @(posedge clk) #1 chk("rst_hold_y_r", 16'(ifa.Y_r), 16'h0);
        @(negedge clk) rst_n = 1;
        tick();
        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < 8; k++) w[k] = 16'($urandom);
            drive_a(8'($urandom), 3'($urandom_range(7)), 1'($urandom_range(3) != 0));
            drive_b(3'($urandom_range(7)), 1'($urandom_range(3) != 0));
            tick();
        end
        for (int k = 0; k < 8; k++) w[k] = 16'h1000 + 16'(k);
        for (int s = 0; s < 8; s++) begin
            drive_b(3'(s), 1'b1);
            chk("sweep16", ifb.Y, 16'h1000 + 16'(s));
            tick();
        end
        drive_b(3'd4, 1'b0);
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
